// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - opcodes, instruction field positions and helpers for the register-file port controller
package regfile_ctrl_pkg;

  localparam logic [4:0] OP_LW  = 5'b00000;
  localparam logic [4:0] OP_MOV = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00011;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 27;
  localparam int RD_HI     = 26;
  localparam int RD_LO     = 22;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wr_src_e;

  function automatic logic [31:0] wb_instruction(input logic [4:0] opcode, input logic [4:0] rd);
    logic [31:0] instr;
    instr = '0;
    instr[OPCODE_HI:OPCODE_LO] = opcode;
    instr[RD_HI:RD_LO] = rd;
    return instr;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter, grant in the request cycle
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // ptr=0 favours req[0] on contention, ptr=1 favours req[1]
  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (req[0] && (!req[1] || !ptr)) grant[0] = 1'b1;
    if (req[1] && (!req[0] ||  ptr)) grant[1] = 1'b1;
  end

  // Only a contended grant moves the pointer, and it moves to the loser
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (&req) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/regfile_port_controller.sv
// rtl/regfile_port_controller.sv - shares the register-file write port between ALU and load write-back,
// gates operand reads against a pending-write scoreboard
module regfile_port_controller
  import regfile_ctrl_pkg::*;
#(
  parameter int         NUM_REGS  = 32,
  parameter int         DATA_W    = 32,
  parameter logic [4:0] WB_OPCODE = 5'b00000,
  localparam int        ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                alu_wr_valid,
  output logic                alu_wr_ready,
  input  logic [ADDR_W-1:0]   alu_wr_addr,
  input  logic [DATA_W-1:0]   alu_wr_data,
  input  logic                mem_wr_valid,
  output logic                mem_wr_ready,
  input  logic [ADDR_W-1:0]   mem_wr_addr,
  input  logic [DATA_W-1:0]   mem_wr_data,
  input  logic                rsv_valid,
  output logic                rsv_ready,
  input  logic [ADDR_W-1:0]   rsv_addr,
  input  logic                rd_valid,
  output logic                rd_ready,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic                rf_enable_write,
  output logic [31:0]         rf_instruction,
  output logic [DATA_W-1:0]   rf_data,
  output logic                rf_enable_read,
  output logic [ADDR_W-1:0]   rf_address1,
  output logic [ADDR_W-1:0]   rf_address2,
  output logic [NUM_REGS-1:0] pending
);

  logic [1:0]          grant;
  wr_src_e             wr_src;
  logic                wr_fire;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [ADDR_W-1:0]   wr_stage_addr;
  logic                rsv_fire;
  logic                rd_fire;
  logic [NUM_REGS-1:0] pending_next;

  rr_arbiter2 u_arb (
    .clock (clock),
    .reset (reset),
    .req   ({mem_wr_valid, alu_wr_valid}),
    .grant (grant)
  );

  assign alu_wr_ready = grant[0];
  assign mem_wr_ready = grant[1];
  assign wr_fire      = |grant;
  assign wr_src       = grant[1] ? SRC_MEM : SRC_ALU;
  assign wr_addr      = (wr_src == SRC_MEM) ? mem_wr_addr : alu_wr_addr;
  assign wr_data      = (wr_src == SRC_MEM) ? mem_wr_data : alu_wr_data;

  assign rsv_ready = !pending[rsv_addr];
  assign rsv_fire  = rsv_valid && rsv_ready;

  // A source is unsafe while pending, while being granted now, or while its write is on the port
  always_comb begin
    rd_ready = !pending[rd_addr1] && !pending[rd_addr2];
    if (wr_fire && (rd_addr1 == wr_addr || rd_addr2 == wr_addr)) rd_ready = 1'b0;
    if (rf_enable_write && (rd_addr1 == wr_stage_addr || rd_addr2 == wr_stage_addr)) rd_ready = 1'b0;
  end
  assign rd_fire = rd_valid && rd_ready;

  // Reservation is applied after the clear so a same-edge set wins
  always_comb begin
    pending_next = pending;
    if (wr_fire)  pending_next[wr_addr]  = 1'b0;
    if (rsv_fire) pending_next[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending         <= '0;
      rf_enable_write <= 1'b0;
      rf_instruction  <= '0;
      rf_data         <= '0;
      wr_stage_addr   <= '0;
      rf_enable_read  <= 1'b0;
      rf_address1     <= '0;
      rf_address2     <= '0;
    end else begin
      pending         <= pending_next;
      rf_enable_write <= wr_fire;
      rf_enable_read  <= rd_fire;
      if (wr_fire) begin
        rf_instruction <= wb_instruction(WB_OPCODE, 5'(wr_addr));
        rf_data        <= wr_data;
        wr_stage_addr  <= wr_addr;
      end
      if (rd_fire) begin
        rf_address1 <= rd_addr1;
        rf_address2 <= rd_addr2;
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_controller.sv
// tb/tb_regfile_port_controller.sv - directed and randomized self-checking bench for regfile_port_controller
module tb_regfile_port_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        alu_wr_valid = 1'b0, mem_wr_valid = 1'b0, rsv_valid = 1'b0, rd_valid = 1'b0;
  logic [4:0]  alu_wr_addr = '0, mem_wr_addr = '0, rsv_addr = '0, rd_addr1 = '0, rd_addr2 = '0;
  logic [31:0] alu_wr_data = '0, mem_wr_data = '0;
  logic        alu_wr_ready, mem_wr_ready, rsv_ready, rd_ready;
  logic        rf_enable_write, rf_enable_read;
  logic [31:0] rf_instruction, rf_data, pending;
  logic [4:0]  rf_address1, rf_address2;

  int checks = 0;
  int errors = 0;

  logic [31:0] regs [32];
  logic [31:0] data_out1, data_out2;

  regfile_port_controller dut (
    .clock(clock), .reset(reset),
    .alu_wr_valid(alu_wr_valid), .alu_wr_ready(alu_wr_ready), .alu_wr_addr(alu_wr_addr), .alu_wr_data(alu_wr_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .rsv_valid(rsv_valid), .rsv_ready(rsv_ready), .rsv_addr(rsv_addr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rf_enable_write(rf_enable_write), .rf_instruction(rf_instruction), .rf_data(rf_data),
    .rf_enable_read(rf_enable_read), .rf_address1(rf_address1), .rf_address2(rf_address2),
    .pending(pending)
  );

  always #5 clock = ~clock;

  // Stand-in for the Registers block driven by the controller
  initial for (int i = 0; i < 32; i++) regs[i] = '0;
  always @(posedge clock) if (!reset && rf_enable_write) regs[rf_instruction[26:22]] <= rf_data;
  assign data_out1 = rf_enable_read ? regs[rf_address1] : 32'h0;
  assign data_out2 = rf_enable_read ? regs[rf_address2] : 32'h0;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] pend_m, e_instr, e_data;
  logic        alu_first, e_we, e_re, last_w, ga, gm, er, ed;
  logic [4:0]  e_a1, e_a2, last_wa, wa;
  logic [31:0] wd;

  initial begin
    tick; tick;
    chk("reset_outputs", {rf_enable_write, rf_enable_read, rf_address1, rf_address2, rf_data},
        {1'b0, 1'b0, 5'd0, 5'd0, 32'd0});
    chk("reset_instr_pending", {rf_instruction, pending}, 64'd0);

    // Reset arriving in the same cycle as a write request
    reset = 1'b0;
    tick;
    alu_wr_valid = 1'b1; alu_wr_addr = 5'd5; alu_wr_data = 32'd7; reset = 1'b1;
    tick;
    chk("reset_mid_write", {rf_enable_write, pending}, {1'b0, 32'd0});
    reset = 1'b0; alu_wr_valid = 1'b0;
    tick;
    chk("reset_mid_write_after", rf_enable_write, 1'b0);

    // Single write to R0 then read it back
    alu_wr_valid = 1'b1; alu_wr_addr = 5'd0; alu_wr_data = 32'h7;
    settle;
    chk("single_grant", {alu_wr_ready, mem_wr_ready}, 2'b10);
    tick;
    alu_wr_valid = 1'b0;
    chk("single_issue", {rf_enable_write, rf_instruction, rf_data}, {1'b1, 32'h0, 32'h7});
    chk("unreserved_write_pending", pending, 32'd0);
    rd_valid = 1'b1; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    settle;
    chk("read_blocked_by_write_stage", rd_ready, 1'b0);
    tick;
    chk("read_r0_ready", rd_ready, 1'b1);
    tick;
    rd_valid = 1'b0;
    chk("read_r0_issue", {rf_enable_read, rf_address1, rf_address2}, {1'b1, 5'd0, 5'd0});
    chk("read_r0_data", data_out1, 32'h7);
    tick;
    chk("read_idle", rf_enable_read, 1'b0);

    // Contention: ALU first, then MEM; pointer then favours MEM
    alu_wr_valid = 1'b1; alu_wr_addr = 5'd1; alu_wr_data = 32'd10;
    mem_wr_valid = 1'b1; mem_wr_addr = 5'd2; mem_wr_data = 32'd20;
    settle;
    chk("contend_first", {alu_wr_ready, mem_wr_ready}, 2'b10);
    tick;
    alu_wr_valid = 1'b0;
    chk("contend_issue1", {rf_instruction[26:22], rf_data}, {5'd1, 32'd10});
    settle;
    chk("contend_second", {alu_wr_ready, mem_wr_ready}, 2'b01);
    tick;
    mem_wr_valid = 1'b0;
    chk("contend_issue2", {rf_enable_write, rf_instruction[26:22], rf_data}, {1'b1, 5'd2, 32'd20});
    alu_wr_valid = 1'b1; alu_wr_addr = 5'd6; alu_wr_data = 32'd66;
    mem_wr_valid = 1'b1; mem_wr_addr = 5'd7; mem_wr_data = 32'd77;
    settle;
    chk("contend_rotated", {alu_wr_ready, mem_wr_ready}, 2'b01);
    tick;
    mem_wr_valid = 1'b0;
    settle;
    chk("contend_alu_after", alu_wr_ready, 1'b1);
    tick;
    alu_wr_valid = 1'b0;
    chk("contend_issue4", {rf_instruction[26:22], rf_data}, {5'd6, 32'd66});
    tick;

    // Scoreboard stall on R3
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    settle;
    chk("rsv_r3_ready", rsv_ready, 1'b1);
    tick;
    rsv_valid = 1'b0;
    chk("rsv_r3_pending", pending, 32'h8);
    rd_valid = 1'b1; rd_addr1 = 5'd3; rd_addr2 = 5'd0;
    settle;
    chk("stall_pending", rd_ready, 1'b0);
    tick;
    mem_wr_valid = 1'b1; mem_wr_addr = 5'd3; mem_wr_data = 32'd33;
    settle;
    chk("stall_at_grant", {mem_wr_ready, rd_ready}, 2'b10);
    tick;
    mem_wr_valid = 1'b0;
    chk("stall_write_stage", {rd_ready, pending}, {1'b0, 32'd0});
    tick;
    chk("stall_released", rd_ready, 1'b1);
    tick;
    rd_valid = 1'b0;
    chk("stall_read_issue", {rf_enable_read, rf_address1}, {1'b1, 5'd3});
    tick;

    // Reserve conflict and same-edge set/clear on R4
    rsv_valid = 1'b1; rsv_addr = 5'd4;
    tick;
    chk("rsv_r4_pending", pending[4], 1'b1);
    chk("rsv_r4_twice", rsv_ready, 1'b0);
    rsv_valid = 1'b0;
    alu_wr_valid = 1'b1; alu_wr_addr = 5'd4; alu_wr_data = 32'd40;
    tick;
    alu_wr_valid = 1'b0;
    chk("r4_cleared", pending, 32'd0);
    rsv_valid = 1'b1; rsv_addr = 5'd4;
    alu_wr_valid = 1'b1; alu_wr_addr = 5'd4; alu_wr_data = 32'd44;
    settle;
    chk("same_edge_ready", {rsv_ready, alu_wr_ready}, 2'b11);
    tick;
    rsv_valid = 1'b0; alu_wr_valid = 1'b0;
    chk("same_edge_set_wins", pending, 32'h10);
    alu_wr_valid = 1'b1; alu_wr_addr = 5'd4; alu_wr_data = 32'd45;
    tick;
    alu_wr_valid = 1'b0;
    chk("r4_final_clear", pending, 32'd0);

    // MOV/ADD style operand pair
    alu_wr_valid = 1'b1; alu_wr_addr = 5'd5; alu_wr_data = 32'd9;
    tick;
    alu_wr_valid = 1'b0;
    mem_wr_valid = 1'b1; mem_wr_addr = 5'd3; mem_wr_data = 32'd9;
    tick;
    mem_wr_valid = 1'b0;
    tick;
    rd_valid = 1'b1; rd_addr1 = 5'd5; rd_addr2 = 5'd3;
    settle;
    chk("movadd_ready", rd_ready, 1'b1);
    tick;
    rd_valid = 1'b0;
    chk("movadd_issue", {rf_enable_read, rf_address1, rf_address2}, {1'b1, 5'd5, 5'd3});
    chk("movadd_equal", data_out1, data_out2);
    chk("movadd_value", data_out1, 32'd9);

    // Randomized phase against a reference model
    reset = 1'b1;
    tick;
    reset = 1'b0;
    pend_m = '0; alu_first = 1'b1; e_instr = '0; e_data = '0; e_we = 1'b0; e_re = 1'b0;
    e_a1 = '0; e_a2 = '0; last_w = 1'b0; last_wa = '0;
    for (int c = 0; c < 400; c++) begin
      if (!alu_wr_valid) begin
        alu_wr_valid = 1'($urandom_range(0, 1));
        alu_wr_addr  = 5'($urandom_range(0, 7));
        alu_wr_data  = $urandom;
      end
      if (!mem_wr_valid) begin
        mem_wr_valid = 1'($urandom_range(0, 1));
        mem_wr_addr  = 5'($urandom_range(0, 7));
        mem_wr_data  = $urandom;
      end
      rsv_valid = 1'($urandom_range(0, 1));
      rsv_addr  = 5'($urandom_range(0, 7));
      rd_valid  = 1'($urandom_range(0, 1));
      rd_addr1  = 5'($urandom_range(0, 7));
      rd_addr2  = 5'($urandom_range(0, 7));
      settle;

      ga = alu_wr_valid && (!mem_wr_valid || alu_first);
      gm = mem_wr_valid && (!alu_wr_valid || !alu_first);
      wa = ga ? alu_wr_addr : mem_wr_addr;
      wd = ga ? alu_wr_data : mem_wr_data;
      er = !pend_m[rsv_addr];
      ed = !pend_m[rd_addr1] && !pend_m[rd_addr2]
           && !((ga || gm) && (rd_addr1 == wa || rd_addr2 == wa))
           && !(last_w && (rd_addr1 == last_wa || rd_addr2 == last_wa));
      chk("rnd_handshakes", {alu_wr_ready, mem_wr_ready, rsv_ready, rd_ready}, {ga, gm, er, ed});

      if (alu_wr_valid && mem_wr_valid) alu_first = !ga;
      if (ga || gm) pend_m[wa] = 1'b0;
      if (rsv_valid && er) pend_m[rsv_addr] = 1'b1;
      e_we = ga || gm;
      if (e_we) begin
        e_instr = 32'(wa) << 22;
        e_data  = wd;
      end
      e_re = rd_valid && ed;
      if (e_re) begin
        e_a1 = rd_addr1;
        e_a2 = rd_addr2;
      end

      tick;
      chk("rnd_pending", pending, pend_m);
      chk("rnd_write", {rf_enable_write, rf_instruction, rf_data[30:0]}, {e_we, e_instr, e_data[30:0]});
      chk("rnd_read", {rf_enable_read, rf_address1, rf_address2, rf_data[31]}, {e_re, e_a1, e_a2, e_data[31]});
      last_w = e_we; last_wa = wa;
      if (ga) alu_wr_valid = 1'b0;
      if (gm) mem_wr_valid = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
